// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: FSM states and constants for the serial pattern transmitter
package seq_pattern_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
endpackage

// File: rtl/seq_lfsr8.sv
// seq_lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances while en is high
module seq_lfsr8
  import seq_pattern_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic q
);
  logic [7:0] r;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r <= LFSR_SEED;
    else if (en) r <= {r[6:0], ^(r & LFSR_TAPS)};
  assign q = r[7];
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern burst transmitter; SEQ_TX_LFSR_FILL_EN fills gaps with LFSR noise
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_vld,
  output logic             frame_sop,
  output logic             busy,
  output logic             done
);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PAT_W - 1);
  state_t state, state_n;
  logic [PAT_W-1:0] pat_q, sh, sh_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] frm, frm_n;
  logic [GAP_W-1:0] gap_q, gcnt, gcnt_n;
  logic out_d, vld_d, sop_d, busy_d, done_d, fill;
`ifdef SEQ_TX_LFSR_FILL_EN
  localparam bit FILL = 1'b1;
  seq_lfsr8 u_lfsr (.clk(clk), .rstn(rstn), .en(state_n == GAP), .q(fill));
`else
  localparam bit FILL = 1'b0;
  assign fill = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      {pat_q, sh, idx, frm, gap_q, gcnt} <= '0;
      {out, out_vld, frame_sop, busy, done} <= '0;
    end else begin
      state <= state_n;
      {sh, idx, frm, gcnt} <= {sh_n, idx_n, frm_n, gcnt_n};
      {out, out_vld, frame_sop, busy, done} <= {out_d, vld_d, sop_d, busy_d, done_d};
      if (state == IDLE && start) {pat_q, gap_q} <= {pattern, gap};
    end
  // datapath registers already hold the next frame when leaving SHIFT, so GAP only counts
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    frm_n = frm;
    gcnt_n = gcnt;
    case (state)
      IDLE: if (start) begin
        state_n = reps == '0 ? DONE : SHIFT;
        sh_n = pattern;
        idx_n = LAST;
        frm_n = reps;
      end
      SHIFT: begin
        sh_n = sh << 1;
        idx_n = idx - 1'b1;
        if (idx == '0) begin
          frm_n = frm - 1'b1;
          state_n = frm == CNT_W'(1) ? DONE : gap_q == '0 ? SHIFT : GAP;
          sh_n = pat_q;
          idx_n = LAST;
          gcnt_n = gap_q;
        end
      end
      GAP: begin
        gcnt_n = gcnt - 1'b1;
        state_n = gcnt == GAP_W'(1) ? SHIFT : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    out_d = state_n == SHIFT ? sh_n[PAT_W-1] : (state_n == GAP) && fill;
    vld_d = state_n == SHIFT || (FILL && state_n == GAP);
    sop_d = state_n == SHIFT && idx_n == LAST;
    busy_d = state_n == SHIFT || state_n == GAP;
    done_d = state_n == DONE;
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx with directed bursts
module tb_seq_pattern_tx;
  import seq_pattern_pkg::*;
  typedef struct {bit is_done; bit b; bit sop; int cyc;} exp_t;
  logic clk = 0, rstn = 0, start = 0;
  logic [3:0] pattern = '0;
  logic [7:0] reps = '0;
  logic [3:0] gap = '0;
  logic out, out_vld, frame_sop, busy, done;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0, busy_cnt = 0, hits = 0;
  logic [3:0] hist = '0;

  seq_pattern_tx dut (
    .clk(clk), .rstn(rstn), .start(start), .pattern(pattern), .reps(reps), .gap(gap),
    .out(out), .out_vld(out_vld), .frame_sop(frame_sop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: 1001 detector that forgets its history whenever out_vld drops
  always @(posedge clk) begin
    #1;
    if (busy) busy_cnt++;
    hist = out_vld ? {hist[2:0], out} : 4'b0;
    if (out_vld && hist == 4'b1001) hits++;
    if (done) done_cnt++;
    if (out_vld || done) begin
      if (q.size() == 0) check("unexpected_output", {done, out_vld, out, frame_sop}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("cycle", cyc, e.cyc);
        check("outputs", {done, out_vld, out, frame_sop, busy},
              {e.is_done, !e.is_done, e.b, e.sop, !e.is_done});
      end
    end
  end

  task automatic burst(input logic [3:0] p, input int r, input int g, input bit poke, input int exp_hits);
    int a, d0, b0, h0, n;
    @(negedge clk);
    a = cyc + 1;
    d0 = done_cnt;
    b0 = busy_cnt;
    h0 = hits;
    for (int f = 0; f < r; f++)
      for (int b = 0; b < 4; b++)
        q.push_back('{1'b0, p[3-b], b == 0, a + f * (4 + g) + b});
    q.push_back('{1'b1, 1'b0, 1'b0, r == 0 ? a : a + r * 4 + (r - 1) * g});
    start = 1; pattern = p; reps = r[7:0]; gap = g[3:0];
    @(negedge clk);
    start = 0; pattern = ~p; reps = 8'd7; gap = 4'd9;
    if (poke) begin
      start = 1;
      repeat (2) @(negedge clk);
      start = 0;
    end
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("burst_timeout", n < 2000, 1);
    if (done) begin
      start = 1; pattern = 4'hF; reps = 8'd1;
      @(negedge clk);
      start = 0;
    end
    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_cycles", busy_cnt - b0, r == 0 ? 0 : r * 4 + (r - 1) * g);
    check("detector_hits", hits - h0, exp_hits);
    q.delete();
  endtask

  initial begin
    int a, d0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {out, out_vld, frame_sop, busy, done}, 0);
    rstn = 1;
    burst(4'b1001, 1, 0, 0, 1);
    burst(4'b1001, 3, 2, 0, 3);
    burst(4'b1001, 3, 0, 0, 3);
    burst(4'b1001, 0, 0, 0, 0);
    burst(4'b1001, 2, 1, 1, 2);
    burst(4'b1100, 2, 0, 0, 1);
    burst(4'b0110, 2, 15, 0, 0);
    burst(4'b1001, 255, 0, 0, 255);
    @(negedge clk);
    a = cyc + 1;
    d0 = done_cnt;
    for (int b = 0; b < 3; b++) q.push_back('{1'b0, 1'b1, b == 0, a + b});
    start = 1; pattern = 4'b1111; reps = 8'd2; gap = 4'd0;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rstn = 0;
    #1;
    check("async_reset", {out, out_vld, frame_sop, busy, done}, 0);
    repeat (3) @(negedge clk);
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_queue_drained", q.size(), 0);
    rstn = 1;
    burst(DEFAULT_PATTERN, 1, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
